// File: rtl/fc_weight_streamer.sv
// fc_weight_streamer: reads TOTAL weight/bias bytes from a 1-cycle-latency
// parameter memory and streams them to the FC layer one byte per cycle,
// honouring i_hold back-pressure and confirming via i_weight_done.
// Optional build macro FC_STREAM_CHECKSUM_EN adds o_checksum, a 16-bit sum
// of every byte emitted since the last accepted start.
module fc_weight_streamer #(
    parameter int INPUT_NUM   = 48,
    parameter int OUTPUT_NUM  = 16,
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_hold,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_weight_valid,
    output logic [7:0]        o_filter,
    input  logic              i_weight_done,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
`ifdef FC_STREAM_CHECKSUM_EN
    ,
    output logic [15:0]       o_checksum
`endif
);

    localparam int TOTAL = INPUT_NUM * OUTPUT_NUM + OUTPUT_NUM;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [CNT_W-1:0]  tx_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [1:0]        occ_q;
    logic [1:0][7:0]   fifo_q;
    logic [1:0][7:0]   fifo_d;
    logic              rd_en_q;
    logic              rvalid_q;   // memory data is on i_mem_rdata this cycle
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic [7:0]        filter_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
`ifdef FC_STREAM_CHECKSUM_EN
    logic [15:0]       csum_q;
`endif

    logic       streaming;
    logic       early_ack;
    logic       pop;
    logic       bypass;
    logic       push;
    logic       load;
    logic [7:0] load_byte;
    logic [2:0] credit;
    logic       issue;

    // Per-cycle handshake decisions: what returns, what leaves, whether to read.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later lines see earlier results.
        streaming = (state_q == S_STREAM);
        early_ack = streaming && i_weight_done;
        pop       = streaming && !early_ack && !i_hold && (occ_q != 2'd0);
        bypass    = streaming && !early_ack && !i_hold && rvalid_q && (occ_q == 2'd0);
        push      = streaming && !early_ack && rvalid_q && !bypass;
        load      = pop || bypass;
        load_byte = pop ? fifo_q[0] : i_mem_rdata;
        // Bytes inside the block never exceed two, so this cannot underflow;
        // a byte leaving at this edge frees its slot for a read at the same edge.
        credit    = 3'd2 - {1'b0, occ_q} - {2'b00, rd_en_q} - {2'b00, rvalid_q}
                    + {2'b00, load};
        issue     = streaming && !early_ack && !i_hold
                    && (rd_cnt_q < CNT_W'(TOTAL)) && (credit != 3'd0);
    end

    // FIFO next contents: head shifts out on pop, returned byte lands behind survivors.
    always_comb begin
        // NOTE: assign a default first so no path leaves fifo_d unassigned (no latch).
        fifo_d = fifo_q;
        if (pop) begin
            fifo_d[0] = fifo_q[1];
        end
        if (push) begin
            if (occ_q == {1'b0, pop}) begin
                fifo_d[0] = i_mem_rdata;
            end else begin
                fifo_d[1] = i_mem_rdata;
            end
        end
    end

    // FIFO payload storage; which entries are live is tracked by occ_q.
    // NOTE: data-only storage is deliberately unreset; occ_q (reset) defines validity.
    always_ff @(posedge i_clk) begin
        fifo_q <= fifo_d;
    end

    // Control FSM with registered outputs, counters and FIFO occupancy.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            rd_cnt_q <= '0;
            tx_cnt_q <= '0;
            to_cnt_q <= '0;
            occ_q    <= 2'd0;
            rd_en_q  <= 1'b0;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            filter_q <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef FC_STREAM_CHECKSUM_EN
            csum_q   <= 16'h0000;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so all registers update together.
            rd_en_q  <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= rd_en_q;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        // The first read goes out with the start so beat 0 lands in cycle 3.
                        state_q  <= S_STREAM;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        tx_cnt_q <= '0;
                        rd_cnt_q <= CNT_W'(1);
                        rd_en_q  <= 1'b1;
                        addr_q   <= BASE;
                        occ_q    <= 2'd0;
`ifdef FC_STREAM_CHECKSUM_EN
                        csum_q   <= 16'h0000;
`endif
                    end
                end
                S_STREAM: begin
                    if (early_ack) begin
                        // Consumer lost sync: abandon queued and in-flight bytes.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        occ_q   <= 2'd0;
                    end else begin
                        occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
                        if (issue) begin
                            rd_en_q  <= 1'b1;
                            addr_q   <= BASE + ADDR_W'(rd_cnt_q);
                            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                        end
                        if (load) begin
                            valid_q  <= 1'b1;
                            filter_q <= load_byte;
                            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
`ifdef FC_STREAM_CHECKSUM_EN
                            csum_q   <= csum_q + {8'h00, load_byte};
`endif
                            if (tx_cnt_q == CNT_W'(TOTAL - 1)) begin
                                state_q  <= S_WAIT_ACK;
                                to_cnt_q <= '0;
                            end
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (i_weight_done) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_rd_en    = rd_en_q;
    assign o_mem_addr     = addr_q;
    assign o_weight_valid = valid_q;
    assign o_filter       = filter_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_err          = err_q;
`ifdef FC_STREAM_CHECKSUM_EN
    assign o_checksum     = csum_q;
`endif

endmodule

// File: tb/tb_fc_weight_streamer.sv
// tb_fc_weight_streamer: directed bench for fc_weight_streamer.
// Memory model returns mem[a] = a[7:0] ^ 8'h5A one cycle after each read.
// Honours FC_STREAM_CHECKSUM_EN to connect and check o_checksum.
module tb_fc_weight_streamer;

    localparam int INPUT_NUM   = 48;
    localparam int OUTPUT_NUM  = 16;
    localparam int ADDR_W      = 10;
    localparam int BASE_ADDR   = 0;
    localparam int ACK_TIMEOUT = 16;
    localparam int TOTAL       = INPUT_NUM * OUTPUT_NUM + OUTPUT_NUM;

    logic              clk;
    logic              rst;
    logic              start;
    logic              hold;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              weight_valid;
    logic [7:0]        filter;
    logic              weight_done;
    logic              busy;
    logic              done;
    logic              err;
`ifdef FC_STREAM_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    fc_weight_streamer #(
        .INPUT_NUM  (INPUT_NUM),
        .OUTPUT_NUM (OUTPUT_NUM),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_hold        (hold),
        .o_mem_rd_en   (mem_rd_en),
        .o_mem_addr    (mem_addr),
        .i_mem_rdata   (mem_rdata),
        .o_weight_valid(weight_valid),
        .o_filter      (filter),
        .i_weight_done (weight_done),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err)
`ifdef FC_STREAM_CHECKSUM_EN
        ,
        .o_checksum    (checksum)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Per-run observations.
    int          beats;
    int          reads;
    int          done_pulses;
    int          err_cyc;
    int          first_cyc;
    int          last_cyc;
    int          first_rd_cyc;
    int          done_cyc;
    int          idle_cyc;
    int          cyc100;
    int          cyc101;
    bit          reset_hit;
    logic [15:0] exp_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pattern(input int a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Synchronous parameter memory, one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= pattern(int'(mem_addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One transfer: start in cycle 0, then observe/drive cycle by cycle.
    // hold_mode: 0 none, 1 five cycles from beat 100, 2 toggle every cycle.
    // ack_mode : 0 ack one cycle after last beat, 1 ack after beat 50,
    //            2 never ack, 3 async reset while beat 300 is on the bus.
    task automatic run_stream(input int hold_mode, input int ack_mode,
                              input int start_at, input int max_cycles);
        int hold_left;
        bit ack_pending;
        bit prev_hold;
        beats = 0; reads = 0; done_pulses = 0; err_cyc = -1;
        first_cyc = -1; last_cyc = -1; first_rd_cyc = -1;
        done_cyc = -1; idle_cyc = -1; cyc100 = -1; cyc101 = -1; reset_hit = 0;
        hold_left = 0; ack_pending = 0; prev_hold = 0;
        start = 1'b1; hold = 1'b0; weight_done = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c < max_cycles; c++) begin
            if (mem_rd_en) begin
                check("rd_addr", 32'(mem_addr), 32'(BASE_ADDR + reads));
                if (first_rd_cyc < 0) first_rd_cyc = c;
                reads++;
            end
            if (prev_hold) check("hold_stall", {30'd0, mem_rd_en, weight_valid}, 32'd0);
            if (weight_valid) begin
                check("beat_data", 32'(filter), 32'(pattern(BASE_ADDR + beats)));
                if (first_cyc < 0) first_cyc = c;
                if (beats == 100) cyc100 = c;
                if (beats == 101) cyc101 = c;
                last_cyc = c;
                beats++;
            end
            check("inflight_bound", 32'((reads - beats) <= 2), 32'd1);
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (err && err_cyc < 0) err_cyc = c;
            if (ack_mode == 3 && weight_valid && beats == 301) begin
                #2 rst = 1'b0;
                #1;
                check("reset_async_outputs",
                      32'({mem_rd_en, mem_addr, weight_valid, filter, busy, done, err}), 32'd0);
`ifdef FC_STREAM_CHECKSUM_EN
                check("reset_async_checksum", 32'(checksum), 32'd0);
`endif
                reset_hit = 1;
                break;
            end
            if (!busy) begin
                idle_cyc = c;
                break;
            end
            weight_done = ack_pending;
            ack_pending = (ack_mode == 0 && weight_valid && beats == TOTAL)
                       || (ack_mode == 1 && weight_valid && beats == 51);
            if (hold_mode == 1) begin
                if (weight_valid && beats == 101) hold_left = 5;
                hold = (hold_left > 0);
                if (hold_left > 0) hold_left--;
            end else if (hold_mode == 2) begin
                hold = c[0];
            end else begin
                hold = 1'b0;
            end
            start = (c == start_at);
            prev_hold = hold;
            tick();
        end
        start = 1'b0; hold = 1'b0; weight_done = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; hold = 1'b0; weight_done = 1'b0;
        exp_sum = 16'h0000;
        for (int k = 0; k < TOTAL; k++) exp_sum = exp_sum + {8'h00, pattern(BASE_ADDR + k)};

        // Reset state.
        tick(); tick(); tick();
        check("reset_outputs",
              32'({mem_rd_en, mem_addr, weight_valid, filter, busy, done, err}), 32'd0);
        rst = 1'b1;
        tick();

        // Basic stream, hold low.
        run_stream(0, 0, -1, 1000);
        check("basic_first_read_cycle", 32'(first_rd_cyc), 32'd1);
        check("basic_beats", 32'(beats), 32'(TOTAL));
        check("basic_first_beat_cycle", 32'(first_cyc), 32'd3);
        check("basic_last_beat_cycle", 32'(last_cyc), 32'(TOTAL + 2));
        check("basic_done_pulses", 32'(done_pulses), 32'd1);
        check("basic_done_cycle", 32'(done_cyc), 32'(TOTAL + 4));
        check("basic_idle_cycle", 32'(idle_cyc), 32'(TOTAL + 5));
        check("basic_err", 32'(err_cyc), 32'hFFFF_FFFF);
`ifdef FC_STREAM_CHECKSUM_EN
        check("basic_checksum", 32'(checksum), 32'(exp_sum));
`endif

        // Single five-cycle hold at beat 100.
        run_stream(1, 0, -1, 1000);
        check("hold1_beats", 32'(beats), 32'(TOTAL));
        check("hold1_resume_gap", 32'(cyc101 - cyc100), 32'd6);
        check("hold1_last_beat_cycle", 32'(last_cyc), 32'(TOTAL + 7));
        check("hold1_done_pulses", 32'(done_pulses), 32'd1);
        check("hold1_err", 32'(err_cyc), 32'hFFFF_FFFF);

        // Hold toggling every cycle.
        run_stream(2, 0, -1, 3000);
        check("alt_beats", 32'(beats), 32'(TOTAL));
        check("alt_done_pulses", 32'(done_pulses), 32'd1);
        check("alt_err", 32'(err_cyc), 32'hFFFF_FFFF);

        // Early acknowledge after beat 50.
        run_stream(0, 1, -1, 1000);
        check("early_beats", 32'(beats), 32'd52);
        check("early_err_cycle", 32'(err_cyc), 32'd55);
        check("early_idle_cycle", 32'(idle_cyc), 32'd55);
        check("early_valid_drop", 32'(weight_valid), 32'd0);
        check("early_done_pulses", 32'(done_pulses), 32'd0);
        tick();
        check("early_quiet_1", 32'({mem_rd_en, weight_valid, busy}), 32'd0);
        tick();
        check("early_quiet_2", 32'({mem_rd_en, weight_valid, busy, err}), 32'd1);

        // Restart after the error: o_err clears and reads restart at BASE_ADDR.
        run_stream(0, 0, -1, 1000);
        check("restart_first_read_cycle", 32'(first_rd_cyc), 32'd1);
        check("restart_beats", 32'(beats), 32'(TOTAL));
        check("restart_err", 32'(err_cyc), 32'hFFFF_FFFF);
        check("restart_done_pulses", 32'(done_pulses), 32'd1);

        // Acknowledge timeout.
        run_stream(0, 2, -1, 1000);
        check("timeout_beats", 32'(beats), 32'(TOTAL));
        check("timeout_err_delay", 32'(err_cyc - last_cyc), 32'(ACK_TIMEOUT));
        check("timeout_idle_cycle", 32'(idle_cyc), 32'(err_cyc));
        check("timeout_done_pulses", 32'(done_pulses), 32'd0);
        tick();
        check("timeout_err_sticky", 32'({err, done, busy}), 32'b100);

        // Asynchronous reset mid-stream at beat 300.
        run_stream(0, 3, -1, 1000);
        check("reset_hit", 32'(reset_hit), 32'd1);
        tick();
        check("reset_held_outputs",
              32'({mem_rd_en, mem_addr, weight_valid, filter, busy, done, err}), 32'd0);
        rst = 1'b1;
        tick();

        // Restart after reset, with a start pulse during the stream that must be ignored.
        run_stream(0, 0, 200, 1000);
        check("post_reset_beats", 32'(beats), 32'(TOTAL));
        check("post_reset_first_beat_cycle", 32'(first_cyc), 32'd3);
        check("post_reset_last_beat_cycle", 32'(last_cyc), 32'(TOTAL + 2));
        check("post_reset_done_pulses", 32'(done_pulses), 32'd1);
        check("post_reset_err", 32'(err_cyc), 32'hFFFF_FFFF);
`ifdef FC_STREAM_CHECKSUM_EN
        check("post_reset_checksum", 32'(checksum), 32'(exp_sum));
        tick();
        check("checksum_stable", 32'(checksum), 32'(exp_sum));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
